ux607_icb_pwm_buf: RTL and testbench

UX607_ICB_PWM_BUF -- requirements
Module: ux607_icb_pwm_buf

---
 rtl/ux607_defines.sv | 15 +
 rtl/ux607_icb_fifo.sv | 74 +++++++
 rtl/ux607_icb_pwm_buf.sv | 131 +++++++++++++
 tb/tb_ux607_icb_pwm_buf.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ux607_defines.sv
`ifndef UX607_DEFINES_SV
`define UX607_DEFINES_SV
// ============================================================================
//  Module      : ux607_defines (shared macro definitions)
//  Description : Physical-address width and ICB data width shared by the
//                UX607 ICB peripherals.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`define UX607_PA_SIZE 32
`define UX607_ICB_DW  32

`default_nettype wire
`endif

// File: rtl/ux607_icb_fifo.sv
`ifndef UX607_PA_SIZE
`include "ux607_defines.sv"
`endif
`default_nettype none
// ============================================================================
//  Module      : ux607_icb_fifo
//  Description : Generic synchronous FIFO with wrap-bit pointers. Full/empty
//                and occupancy come from registered pointers only; data
//                storage is not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ux607_icb_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_en,
    input  logic [DW-1:0]          i_wr_data,
    input  logic                   i_rd_en,
    output logic [DW-1:0]          o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_PW = $clog2(DEPTH) + 1;
    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Pointer XOR equals exactly the wrap bit when the FIFO is full
    localparam logic [c_PW-1:0] c_FULL_XOR = c_PW'(DEPTH);

    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_IW-1:0] w_widx;
    logic [c_IW-1:0] w_ridx;
    logic            w_wr;
    logic            w_rd;

    generate
        if (DEPTH > 1) begin : g_multi
            assign w_widx = r_wptr[c_IW-1:0];
            assign w_ridx = r_rptr[c_IW-1:0];
        end else begin : g_single
            assign w_widx = '0;
            assign w_ridx = '0;
        end
    endgenerate

    assign o_full    = ((r_wptr ^ r_rptr) == c_FULL_XOR);
    assign o_empty   = (r_wptr == r_rptr);
    assign o_count   = r_wptr - r_rptr;
    assign o_rd_data = r_mem[w_ridx];
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;

    // Pointer advance; both wrap naturally modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + c_PW'(1);
            if (w_rd) r_rptr <= r_rptr + c_PW'(1);
        end
    end

    // Storage write, intentionally without reset
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_widx] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/ux607_icb_pwm_buf.sv
`ifndef UX607_PA_SIZE
`include "ux607_defines.sv"
`endif
`default_nettype none
// ============================================================================
//  Module      : ux607_icb_pwm_buf
//  Description : ICB command/response buffer in front of the PWM block.
//                Commands are only issued downstream when a response slot is
//                guaranteed, so the response FIFO never back-pressures the
//                PWM while commands are outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module ux607_icb_pwm_buf #(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // Upstream ICB slave
    input  logic                      i_icb_cmd_valid,
    output logic                      i_icb_cmd_ready,
    input  logic [`UX607_PA_SIZE-1:0] i_icb_cmd_addr,
    input  logic                      i_icb_cmd_read,
    input  logic [`UX607_ICB_DW-1:0]  i_icb_cmd_wdata,
    output logic                      i_icb_rsp_valid,
    input  logic                      i_icb_rsp_ready,
    output logic [`UX607_ICB_DW-1:0]  i_icb_rsp_rdata,
    // Downstream ICB master
    output logic                      o_icb_cmd_valid,
    input  logic                      o_icb_cmd_ready,
    output logic [`UX607_PA_SIZE-1:0] o_icb_cmd_addr,
    output logic                      o_icb_cmd_read,
    output logic [`UX607_ICB_DW-1:0]  o_icb_cmd_wdata,
    input  logic                      o_icb_rsp_valid,
    output logic                      o_icb_rsp_ready,
    input  logic [`UX607_ICB_DW-1:0]  o_icb_rsp_rdata,
    // Status
    output logic                      o_idle
);

    localparam int c_PA = `UX607_PA_SIZE;
    localparam int c_DW = `UX607_ICB_DW;
    localparam int c_CW = c_PA + 1 + c_DW;
    localparam int c_PW = $clog2(DEPTH) + 1;
    localparam logic [c_PW:0] c_DEPTH_EXT = (c_PW + 1)'(DEPTH);

    logic [c_CW-1:0] w_cmd_in;
    logic [c_CW-1:0] w_cmd_head;
    logic            w_cmd_full;
    logic            w_cmd_empty;
    logic [c_PW-1:0] w_cmd_count;
    logic            w_rsp_full;
    logic            w_rsp_empty;
    logic [c_PW-1:0] w_rsp_count;
    logic [c_PW:0]   w_credit_sum;
    logic            w_up_cmd_hs;
    logic            w_dn_cmd_hs;
    logic            w_dn_rsp_hs;
    logic            w_up_rsp_pop;
    logic [c_PW-1:0] r_outs_cnt;

    assign w_cmd_in = {i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata};
    assign {o_icb_cmd_addr, o_icb_cmd_read, o_icb_cmd_wdata} = w_cmd_head;

    assign i_icb_cmd_ready = ~w_cmd_full;
    assign w_up_cmd_hs     = i_icb_cmd_valid & ~w_cmd_full;

    // Outstanding commands plus buffered responses must leave a free slot
    assign w_credit_sum    = {1'b0, r_outs_cnt} + {1'b0, w_rsp_count};
    assign o_icb_cmd_valid = ~w_cmd_empty & (w_credit_sum < c_DEPTH_EXT);
    assign w_dn_cmd_hs     = o_icb_cmd_valid & o_icb_cmd_ready;

    assign o_icb_rsp_ready = ~w_rsp_full;
    assign w_dn_rsp_hs     = o_icb_rsp_valid & ~w_rsp_full;

    assign i_icb_rsp_valid = ~w_rsp_empty;
    assign w_up_rsp_pop    = i_icb_rsp_ready & ~w_rsp_empty;

    assign o_idle = (w_cmd_count == '0) & w_rsp_empty & (r_outs_cnt == '0);

    ux607_icb_fifo #(
        .DW    (c_CW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_up_cmd_hs),
        .i_wr_data (w_cmd_in),
        .i_rd_en   (w_dn_cmd_hs),
        .o_rd_data (w_cmd_head),
        .o_full    (w_cmd_full),
        .o_empty   (w_cmd_empty),
        .o_count   (w_cmd_count)
    );

    ux607_icb_fifo #(
        .DW    (c_DW),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_dn_rsp_hs),
        .i_wr_data (o_icb_rsp_rdata),
        .i_rd_en   (w_up_rsp_pop),
        .o_rd_data (i_icb_rsp_rdata),
        .o_full    (w_rsp_full),
        .o_empty   (w_rsp_empty),
        .o_count   (w_rsp_count)
    );

    // Outstanding-command counter: issue increments, response decrements
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outs_cnt <= '0;
        end else begin
            case ({w_dn_cmd_hs, w_dn_rsp_hs})
                2'b10:   r_outs_cnt <= r_outs_cnt + c_PW'(1);
                2'b01:   r_outs_cnt <= r_outs_cnt - c_PW'(1);
                default: r_outs_cnt <= r_outs_cnt;
            endcase
        end
    end

    // A downstream response with nothing outstanding is a protocol violation
    always_ff @(posedge clk) begin
        if (rst_n && w_dn_rsp_hs) begin
            assert (r_outs_cnt != '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ux607_icb_pwm_buf.sv
`ifndef UX607_PA_SIZE
`include "ux607_defines.sv"
`endif
`default_nettype none
// ============================================================================
//  Module      : tb_ux607_icb_pwm_buf
//  Description : Directed self-checking bench for ux607_icb_pwm_buf (DEPTH=2)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ux607_icb_pwm_buf;

    localparam int PA = `UX607_PA_SIZE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_icb_cmd_valid;
    logic          i_icb_cmd_ready;
    logic [PA-1:0] i_icb_cmd_addr;
    logic          i_icb_cmd_read;
    logic [31:0]   i_icb_cmd_wdata;
    logic          i_icb_rsp_valid;
    logic          i_icb_rsp_ready;
    logic [31:0]   i_icb_rsp_rdata;
    logic          o_icb_cmd_valid;
    logic          o_icb_cmd_ready;
    logic [PA-1:0] o_icb_cmd_addr;
    logic          o_icb_cmd_read;
    logic [31:0]   o_icb_cmd_wdata;
    logic          o_icb_rsp_valid;
    logic          o_icb_rsp_ready;
    logic [31:0]   o_icb_rsp_rdata;
    logic          o_idle;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ux607_icb_pwm_buf #(.DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_icb_cmd_valid (i_icb_cmd_valid),
        .i_icb_cmd_ready (i_icb_cmd_ready),
        .i_icb_cmd_addr  (i_icb_cmd_addr),
        .i_icb_cmd_read  (i_icb_cmd_read),
        .i_icb_cmd_wdata (i_icb_cmd_wdata),
        .i_icb_rsp_valid (i_icb_rsp_valid),
        .i_icb_rsp_ready (i_icb_rsp_ready),
        .i_icb_rsp_rdata (i_icb_rsp_rdata),
        .o_icb_cmd_valid (o_icb_cmd_valid),
        .o_icb_cmd_ready (o_icb_cmd_ready),
        .o_icb_cmd_addr  (o_icb_cmd_addr),
        .o_icb_cmd_read  (o_icb_cmd_read),
        .o_icb_cmd_wdata (o_icb_cmd_wdata),
        .o_icb_rsp_valid (o_icb_rsp_valid),
        .o_icb_rsp_ready (o_icb_rsp_ready),
        .o_icb_rsp_rdata (o_icb_rsp_rdata),
        .o_idle          (o_idle)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_icb_cmd_valid = 1'b0;
        i_icb_cmd_addr  = '0;
        i_icb_cmd_read  = 1'b0;
        i_icb_cmd_wdata = '0;
        i_icb_rsp_ready = 1'b1;
        o_icb_cmd_ready = 1'b0;
        o_icb_rsp_valid = 1'b0;
        o_icb_rsp_rdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_cmd(input logic [31:0] addr, input logic rd);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = addr;
        i_icb_cmd_read  = rd;
        i_icb_cmd_wdata = ~addr;
    endtask

    // Response data the bench's PWM model returns for an address
    function automatic logic [31:0] pwm_data(input logic [31:0] addr);
        return addr ^ 32'h5A5A_A5A5;
    endfunction

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++; if (i_icb_cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b exp 1", i_icb_cmd_ready); else n_pass++;
        n_checks++; if (o_icb_cmd_valid !== 1'b0) $display("FAIL rst_dn_cmd_valid: got %b exp 0", o_icb_cmd_valid); else n_pass++;
        n_checks++; if (i_icb_rsp_valid !== 1'b0) $display("FAIL rst_up_rsp_valid: got %b exp 0", i_icb_rsp_valid); else n_pass++;
        n_checks++; if (o_icb_rsp_ready !== 1'b1) $display("FAIL rst_dn_rsp_ready: got %b exp 1", o_icb_rsp_ready); else n_pass++;
        n_checks++; if (o_idle !== 1'b1) $display("FAIL rst_idle: got %b exp 1", o_idle); else n_pass++;
    endtask

    task automatic test_single_write;
        do_reset();
        o_icb_cmd_ready = 1'b1;
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = 32'h1000_0004;
        i_icb_cmd_read  = 1'b0;
        i_icb_cmd_wdata = 32'h0000_00FF;
        n_checks++; if (o_icb_cmd_valid !== 1'b0) $display("FAIL sw_no_bypass: got %b exp 0", o_icb_cmd_valid); else n_pass++;
        tick();
        i_icb_cmd_valid = 1'b0;
        n_checks++; if (o_icb_cmd_valid !== 1'b1) $display("FAIL sw_dn_valid: got %b exp 1", o_icb_cmd_valid); else n_pass++;
        n_checks++; if (o_icb_cmd_addr !== 32'h1000_0004) $display("FAIL sw_dn_addr: got %h exp 10000004", o_icb_cmd_addr); else n_pass++;
        n_checks++; if (o_icb_cmd_read !== 1'b0) $display("FAIL sw_dn_read: got %b exp 0", o_icb_cmd_read); else n_pass++;
        n_checks++; if (o_icb_cmd_wdata !== 32'h0000_00FF) $display("FAIL sw_dn_wdata: got %h exp 000000ff", o_icb_cmd_wdata); else n_pass++;
        n_checks++; if (o_idle !== 1'b0) $display("FAIL sw_busy: got %b exp 0", o_idle); else n_pass++;
        tick();
        n_checks++; if (o_icb_cmd_valid !== 1'b0) $display("FAIL sw_dn_drained: got %b exp 0", o_icb_cmd_valid); else n_pass++;
        o_icb_rsp_valid = 1'b1;
        o_icb_rsp_rdata = 32'h0000_0000;
        n_checks++; if (i_icb_rsp_valid !== 1'b0) $display("FAIL sw_rsp_early: got %b exp 0", i_icb_rsp_valid); else n_pass++;
        tick();
        o_icb_rsp_valid = 1'b0;
        n_checks++; if (i_icb_rsp_valid !== 1'b1) $display("FAIL sw_up_rsp_valid: got %b exp 1", i_icb_rsp_valid); else n_pass++;
        n_checks++; if (i_icb_rsp_rdata !== 32'h0) $display("FAIL sw_up_rsp_rdata: got %h exp 00000000", i_icb_rsp_rdata); else n_pass++;
        tick();
        n_checks++; if (i_icb_rsp_valid !== 1'b0) $display("FAIL sw_rsp_popped: got %b exp 0", i_icb_rsp_valid); else n_pass++;
        n_checks++; if (o_idle !== 1'b1) $display("FAIL sw_idle_back: got %b exp 1", o_idle); else n_pass++;
    endtask

    task automatic test_backpressure;
        do_reset();
        o_icb_cmd_ready = 1'b0;
        push_cmd(32'h1000_0010, 1'b1);
        n_checks++; if (i_icb_cmd_ready !== 1'b1) $display("FAIL bp_ready_1st: got %b exp 1", i_icb_cmd_ready); else n_pass++;
        tick();
        push_cmd(32'h1000_0014, 1'b1);
        n_checks++; if (i_icb_cmd_ready !== 1'b1) $display("FAIL bp_ready_2nd: got %b exp 1", i_icb_cmd_ready); else n_pass++;
        tick();
        push_cmd(32'h1000_0018, 1'b1);
        n_checks++; if (i_icb_cmd_ready !== 1'b0) $display("FAIL bp_full_ready: got %b exp 0", i_icb_cmd_ready); else n_pass++;
        n_checks++; if (o_icb_cmd_addr !== 32'h1000_0010) $display("FAIL bp_head_addr: got %h exp 10000010", o_icb_cmd_addr); else n_pass++;
        tick();
        n_checks++; if (i_icb_cmd_ready !== 1'b0) $display("FAIL bp_still_full: got %b exp 0", i_icb_cmd_ready); else n_pass++;
        n_checks++; if (o_icb_cmd_valid !== 1'b1 || o_icb_cmd_addr !== 32'h1000_0010)
            $display("FAIL bp_held_stable: got valid %b addr %h exp 1 10000010", o_icb_cmd_valid, o_icb_cmd_addr); else n_pass++;
        o_icb_cmd_ready = 1'b1;
        tick();
        n_checks++; if (i_icb_cmd_ready !== 1'b1) $display("FAIL bp_ready_after_hs: got %b exp 1", i_icb_cmd_ready); else n_pass++;
        n_checks++; if (o_icb_cmd_addr !== 32'h1000_0014) $display("FAIL bp_next_head: got %h exp 10000014", o_icb_cmd_addr); else n_pass++;
        tick();
        i_icb_cmd_valid = 1'b0;
        n_checks++; if (o_icb_cmd_valid !== 1'b0) $display("FAIL bp_credit_block: got %b exp 0", o_icb_cmd_valid); else n_pass++;
    endtask

    task automatic test_credit;
        do_reset();
        o_icb_cmd_ready = 1'b1;
        i_icb_rsp_ready = 1'b0;
        push_cmd(32'h1000_0020, 1'b1);
        tick();
        push_cmd(32'h1000_0024, 1'b1);
        tick();
        push_cmd(32'h1000_0028, 1'b1);
        tick();
        i_icb_cmd_valid = 1'b0;
        n_checks++; if (o_icb_cmd_valid !== 1'b0) $display("FAIL cr_outs_block: got %b exp 0", o_icb_cmd_valid); else n_pass++;
        o_icb_rsp_valid = 1'b1;
        o_icb_rsp_rdata = 32'hAAAA_0001;
        tick();
        o_icb_rsp_rdata = 32'hAAAA_0002;
        tick();
        o_icb_rsp_valid = 1'b0;
        n_checks++; if (o_icb_cmd_valid !== 1'b0) $display("FAIL cr_rsp_block: got %b exp 0", o_icb_cmd_valid); else n_pass++;
        n_checks++; if (o_icb_rsp_ready !== 1'b0) $display("FAIL cr_rsp_full: got %b exp 0", o_icb_rsp_ready); else n_pass++;
        n_checks++; if (i_icb_rsp_valid !== 1'b1 || i_icb_rsp_rdata !== 32'hAAAA_0001)
            $display("FAIL cr_rsp_head: got valid %b rdata %h exp 1 aaaa0001", i_icb_rsp_valid, i_icb_rsp_rdata); else n_pass++;
        tick();
        n_checks++; if (o_icb_cmd_valid !== 1'b0) $display("FAIL cr_hold_block: got %b exp 0", o_icb_cmd_valid); else n_pass++;
        i_icb_rsp_ready = 1'b1;
        tick();
        i_icb_rsp_ready = 1'b0;
        n_checks++; if (o_icb_cmd_valid !== 1'b1 || o_icb_cmd_addr !== 32'h1000_0028)
            $display("FAIL cr_release: got valid %b addr %h exp 1 10000028", o_icb_cmd_valid, o_icb_cmd_addr); else n_pass++;
        n_checks++; if (i_icb_rsp_rdata !== 32'hAAAA_0002) $display("FAIL cr_rsp_second: got %h exp aaaa0002", i_icb_rsp_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        o_icb_cmd_ready = 1'b1;
        push_cmd(32'h1000_0030, 1'b0);
        tick();
        push_cmd(32'h1000_0034, 1'b1);
        tick();
        o_icb_cmd_ready = 1'b0;
        push_cmd(32'h1000_0038, 1'b0);
        tick();
        i_icb_cmd_valid = 1'b0;
        n_checks++; if (o_idle !== 1'b0 || o_icb_cmd_valid !== 1'b1)
            $display("FAIL rm_busy_before: got idle %b valid %b exp 0 1", o_idle, o_icb_cmd_valid); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (o_icb_cmd_valid !== 1'b0) $display("FAIL rm_dn_valid: got %b exp 0", o_icb_cmd_valid); else n_pass++;
        n_checks++; if (i_icb_rsp_valid !== 1'b0) $display("FAIL rm_up_rsp_valid: got %b exp 0", i_icb_rsp_valid); else n_pass++;
        n_checks++; if (i_icb_cmd_ready !== 1'b1) $display("FAIL rm_cmd_ready: got %b exp 1", i_icb_cmd_ready); else n_pass++;
        n_checks++; if (o_idle !== 1'b1) $display("FAIL rm_idle: got %b exp 1", o_idle); else n_pass++;
    endtask

    // Traffic scenario with a PWM model; handshakes are predicted from the
    // DUT's registered-only valid/ready outputs before each clock edge.
    task automatic run_traffic(input int n, input bit rnd, input logic [31:0] base, input string tag);
        logic [31:0] exp_q[$];
        logic [31:0] pwm_q[$];
        logic [31:0] exp_d;
        int issued = 0, received = 0, dn_cmds = 0, max_outs = 0, cyc = 0;
        bit rsp_hold = 1'b0;
        do_reset();
        while (received < n && cyc < 2000) begin
            if (issued < n) begin
                i_icb_cmd_valid = !rnd || i_icb_cmd_valid || ($urandom_range(0, 1) == 1);
                push_cmd(base + 32'(issued * 4), issued[0]);
                i_icb_cmd_valid = !rnd || i_icb_cmd_valid;
            end else begin
                i_icb_cmd_valid = 1'b0;
            end
            o_icb_cmd_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (!rsp_hold)
                o_icb_rsp_valid = (pwm_q.size() > 0) && (!rnd || ($urandom_range(0, 1) == 1));
            o_icb_rsp_rdata = (pwm_q.size() > 0) ? pwm_q[0] : 32'h0;
            i_icb_rsp_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (i_icb_cmd_valid && i_icb_cmd_ready) begin
                exp_q.push_back(pwm_data(i_icb_cmd_addr));
                issued++;
            end
            if (o_icb_rsp_valid && o_icb_rsp_ready) begin
                void'(pwm_q.pop_front());
                rsp_hold = 1'b0;
            end else begin
                rsp_hold = o_icb_rsp_valid;
            end
            if (o_icb_cmd_valid && o_icb_cmd_ready) begin
                pwm_q.push_back(pwm_data(o_icb_cmd_addr));
                dn_cmds++;
            end
            if (pwm_q.size() > max_outs) max_outs = pwm_q.size();
            if (i_icb_rsp_valid && i_icb_rsp_ready) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
                n_checks++; if (i_icb_rsp_rdata !== exp_d)
                    $display("FAIL %s_rdata[%0d]: got %h exp %h", tag, received, i_icb_rsp_rdata, exp_d); else n_pass++;
                received++;
            end
            tick();
            cyc++;
        end
        idle_inputs();
        n_checks++; if (received != n) $display("FAIL %s_timeout: got %0d responses exp %0d", tag, received, n); else n_pass++;
        n_checks++; if (dn_cmds != n) $display("FAIL %s_dn_cmds: got %0d exp %0d", tag, dn_cmds, n); else n_pass++;
        n_checks++; if (max_outs > 2) $display("FAIL %s_max_outs: got %0d exp <=2", tag, max_outs); else n_pass++;
        tick();
        n_checks++; if (o_idle !== 1'b1) $display("FAIL %s_idle_end: got %b exp 1", tag, o_idle); else n_pass++;
    endtask

    task automatic test_ordering;
        run_traffic(8, 1'b1, 32'h1000_0100, "ord");
    endtask

    task automatic test_wrap_around;
        run_traffic(20, 1'b0, 32'h2000_0000, "wrap");
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_backpressure();
        test_credit();
        test_reset_mid();
        test_ordering();
        test_wrap_around();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
